// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry and FSM state type for the cache controller.
// Word address layout is {tag, index, word offset}.
package cache_pkg;

    localparam int ADDR_W          = 15;
    localparam int DATA_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int TAG_W           = 3;
    localparam int INDEX_W         = 10;
    localparam int OFFSET_W        = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        FETCH   = 3'd2,
        FILL    = 3'd3,
        RESPOND = 3'd4
    } cache_ctrl_state_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU read request/response bundle.
// master drives the request, slave returns the word.
interface cache_ctrl_if #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W
);

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ready,
        output rdata
    );

endinterface

// File: rtl/cache_fill_buffer.sv
// cache_fill_buffer: collects memory beats into one block.
// Beat counter restarts on clear; words hold until overwritten.
module cache_fill_buffer
    import cache_pkg::*;
#(
    parameter int DATA_W = cache_pkg::DATA_W
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              beat_valid,
    input  logic [DATA_W-1:0]                 beat_data,
    output logic [WORDS_PER_BLOCK*DATA_W-1:0] block,
    output logic                              last_beat
);

    logic [OFFSET_W-1:0]                    beat_q, beat_d;
    logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] block_q, block_d;

    // store each valid beat at the current slot and advance
    always_comb begin
        beat_d  = beat_q;
        block_d = block_q;
        if (clear) begin
            beat_d = '0;
        end else if (beat_valid) begin
            block_d[beat_q] = beat_data;
            beat_d          = beat_q + OFFSET_W'(1);
        end
    end

    // beat counter and block registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q  <= '0;
            block_q <= '0;
        end else begin
            beat_q  <= beat_d;
            block_q <= block_d;
        end
    end

    assign block     = block_q;
    assign last_beat = beat_valid && !clear && (beat_q == '1);

endmodule

// File: rtl/cache_controller.sv
// cache_controller: read-miss controller, 4-word block refill.
// Optional hit/miss counters enabled by CACHE_CTRL_STATS_EN.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W,
    parameter int CNT_W  = 16
)(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cpu_req,
    input  logic [ADDR_W-1:0]                 cpu_addr,
    output logic                              cpu_ready,
    output logic [DATA_W-1:0]                 cpu_rdata,
    output logic [ADDR_W-1:0]                 cache_addr,
    input  logic                              cache_miss,
    input  logic [DATA_W-1:0]                 cache_rdata,
    output logic                              cache_write,
    output logic [WORDS_PER_BLOCK*DATA_W-1:0] cache_block,
    output logic                              mem_req,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic                              mem_valid,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic                              stats_clr,
    output logic [CNT_W-1:0]                  hit_count,
    output logic [CNT_W-1:0]                  miss_count
);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_LOOKUP  = LOOKUP;
    localparam logic [2:0] ST_FETCH   = FETCH;
    localparam logic [2:0] ST_FILL    = FILL;
    localparam logic [2:0] ST_RESPOND = RESPOND;

    logic [2:0]                             state_q, state_d;
    logic [ADDR_W-1:0]                      addr_q, addr_d;
    logic                                   fb_clear;
    logic                                   fb_valid;
    logic                                   fb_last;
    logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] blk_words;

    cache_fill_buffer #(
        .DATA_W (DATA_W)
    ) u_fill (
        .clk        (clk),
        .rst        (rst),
        .clear      (fb_clear),
        .beat_valid (fb_valid),
        .beat_data  (mem_rdata),
        .block      (cache_block),
        .last_beat  (fb_last)
    );

    assign blk_words  = cache_block;
    assign cache_addr = addr_q;
    assign mem_addr   = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

    // next-state and output decode; strobes default low
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        cache_write = 1'b0;
        mem_req     = 1'b0;
        fb_clear    = 1'b0;
        fb_valid    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (!cache_miss) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = cache_rdata;
                    state_d   = ST_IDLE;
                end else begin
                    fb_clear = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req  = 1'b1;
                fb_valid = mem_valid;
                if (fb_last) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                cache_write = 1'b1;
                state_d     = ST_RESPOND;
            end
            ST_RESPOND: begin
                cpu_ready = 1'b1;
                cpu_rdata = blk_words[addr_q[OFFSET_W-1:0]];
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and latched request address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic             hit_evt;
    logic             miss_evt;

    assign hit_evt  = (state_q == ST_LOOKUP) && !cache_miss;
    assign miss_evt = (state_q == ST_LOOKUP) && cache_miss;

    // saturating counters; clear overrides increment
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (stats_clr) begin
            hit_d  = '0;
            miss_d = '0;
        end else begin
            if (hit_evt && (hit_q != '1)) begin
                hit_d = hit_q + CNT_W'(1);
            end
            if (miss_evt && (miss_q != '1)) begin
                miss_d = miss_q + CNT_W'(1);
            end
        end
    end

    // statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    logic stats_unused;

    assign stats_unused = stats_clr;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning word-address width (3-bit tag, 10-bit index, 2-bit word offset).
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning statistics counter width.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cpu_req  in  1  CPU read request, held until cpu_ready
- cpu_addr  in  ADDR_W  CPU word address, stable while cpu_req
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid only when cpu_ready
- cache_addr  out  ADDR_W  address presented to the cache datapath
- cache_miss  in  1  combinational miss flag from the cache for cache_addr
- cache_rdata  in  DATA_W  combinational cache read word
- cache_write  out  1  one-cycle block-write strobe to the cache
- cache_block  out  4 x DATA_W  assembled block, word 0 to word 3
- mem_req  out  1  block fetch request to main memory
- mem_addr  out  ADDR_W  block-aligned fetch address
- mem_valid  in  1  memory data beat valid
- mem_rdata  in  DATA_W  memory beat data
- stats_clr  in  1  synchronous clear of statistics counters
- hit_count  out  CNT_W  saturating hit count
- miss_count  out  CNT_W  saturating miss count

Function
REQ-005 SHALL implement FSM states IDLE, LOOKUP, FETCH, FILL, RESPOND.
REQ-006 IDLE: on cpu_req=1, SHALL latch cpu_addr into addr_q and go to LOOKUP; otherwise stay.
REQ-007 cache_addr SHALL equal addr_q in every state.
REQ-008 LOOKUP with cache_miss=0: SHALL drive cpu_ready=1 and cpu_rdata=cache_rdata in that cycle, then go to IDLE (hit latency 1 cycle after acceptance).
REQ-009 LOOKUP with cache_miss=1: SHALL go to FETCH and clear the beat counter to 0.
REQ-010 FETCH: SHALL hold mem_req=1 and mem_addr={addr_q[ADDR_W-1:2],2'b00}; each mem_valid=1 cycle SHALL store mem_rdata into cache_block word[beat] and increment a 2-bit beat counter; beats may be non-consecutive.
REQ-011 Upon the 4th beat (beat counter=3 with mem_valid=1), SHALL go to FILL; mem_req SHALL be 0 from FILL onward.
REQ-012 FILL: SHALL assert cache_write=1 for exactly one cycle with cache_block stable, then go to RESPOND.
REQ-013 RESPOND: SHALL drive cpu_ready=1 and cpu_rdata=cache_block word[addr_q[1:0]] (from the buffer, not cache_rdata), then go to IDLE.
REQ-014 mem_valid outside FETCH SHALL be ignored, with no buffer or counter change.
REQ-015 cpu_req deasserted mid-transaction SHALL not abort it; cpu_ready still pulses.
REQ-016 cpu_req still high in the cycle after cpu_ready SHALL be accepted as a new request.
REQ-017 cpu_ready, cache_write and mem_req SHALL be 0 in every state and cycle not listed above.
REQ-018 cache_block SHALL hold its last contents outside FETCH.

Reset
REQ-019 rst=1 SHALL asynchronously force state IDLE, addr_q=0, beat counter=0, cache_block=0, and cpu_ready, cache_write and mem_req=0; cpu_rdata SHALL then read 0.
REQ-020 Reset during FETCH SHALL discard any partial block; a subsequent request SHALL restart the fetch from beat 0.

Configuration
REQ-021 With macro CACHE_CTRL_STATS_EN defined: hit_count SHALL increment on each LOOKUP hit; miss_count SHALL increment on each LOOKUP miss; both SHALL saturate at all-ones, clear on stats_clr=1 (clear wins over increment), and reset to 0.
REQ-022 Without CACHE_CTRL_STATS_EN: hit_count and miss_count SHALL be constant 0, stats_clr SHALL be ignored, and no counter flops SHALL exist; the port list is unchanged.

Structure
REQ-023 Package cache_pkg SHALL hold ADDR_W, DATA_W, WORDS_PER_BLOCK=4, TAG_W=3, INDEX_W=10, OFFSET_W=2, and enum cache_ctrl_state_t {IDLE, LOOKUP, FETCH, FILL, RESPOND}.
REQ-024 Beat collection (beat counter plus 4-word register) SHALL be a sub-module cache_fill_buffer with ports clk, rst, clear, beat_valid, beat_data, block, last_beat.

Verification
REQ-025 Hit: cache_miss=0, cache_rdata=32'hDEADBEEF, cpu_addr=15'h0123 -> cpu_ready one cycle after acceptance with cpu_rdata=32'hDEADBEEF; mem_req never 1.
REQ-026 Miss fill: cpu_addr=15'h5A7E, cache_miss=1, beats 32'h10,32'h11,32'h12,32'h13 -> mem_addr=15'h5A7C; one cache_write with block {10,11,12,13}; then cpu_ready with cpu_rdata=32'h12.
REQ-027 Gapped beats: mem_valid with 3 idle cycles between beats -> still exactly 4 stores, one cache_write, correct word returned.
REQ-028 Reset mid-fetch: rst after 2 beats -> outputs 0 immediately; next miss -> full 4-beat fetch, and the stale 2 beats never appear in cache_block.
REQ-029 Stray beat: mem_valid=1 in IDLE with data 32'hFFFFFFFF -> cache_block unchanged, no cache_write.
REQ-030 Stats (CACHE_CTRL_STATS_EN defined, CNT_W=2): 5 hits -> hit_count=3 (saturated); stats_clr coincident with a hit -> hit_count=0; without the macro -> counters stay 0.
